spi_adc_multichannel_receiver: RTL and testbench
================================================

Name: spi_adc_multichannel_receiver

Overview:
- Parametrised successor to the single-channel Pmod MIC3 SPI receiver.
- Drives one shared CS/SCK pair and captures N parallel SDO lines from ADCS7476-class serial ADCs (one per Pmod/mic) at a programmable sample rate.
- Per channel: offset-binary to signed conversion, sign-extension to the lab `mic` width, and a clip flag.
- Sits in board_specific_top between the Pmod pins and lab_top `mic`; one frame-aligned valid strobe covers all channels.

Parameters:
- clk_mhz, 100: system clock frequency in MHz.
- sample_rate_hz, 48000: frame rate. frame_period = clk_mhz*1000000/sample_rate_hz cycles, integer-truncated.
- sck_half, 4: clk cycles per SCK half-period (12.5 MHz SCK at defaults).
- n_ch, 1: number of SDO channels, 1..8.
- frame_bits, 16: SCK cycles per conversion frame.
- w_adc, 12: ADC data bits, the last w_adc bits of the frame, MSB first.
- w_out, 24: output sample width; must be >= w_adc.
- offset_binary, 1: 1 means subtract 2^(w_adc-1) before sign-extension; 0 means treat the raw code as two's complement.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; sampled only at frame boundaries.
- sdo  in  n_ch  serial data from each ADC.
- cs  out  1  shared chip select, active low.
- sck  out  1  shared serial clock; idles high.
- value  out  n_ch*w_out  signed samples; channel k occupies bits [k*w_out +: w_out].
- clip  out  n_ch  per-channel flag; raw code was all-zeros or all-ones in the last frame.
- valid  out  1  one-cycle strobe; value and clip were updated on this cycle.
- busy  out  1  high while cs is low.

Behaviour:
- Reset (async assert, sync deassert internally): cs=1, sck=1, value=0, clip=0, valid=0, busy=0. The frame counter, bit counter and shift registers are cleared; the FSM goes to IDLE.
- Frame counter runs 0..frame_period-1 continuously and wraps to 0 independently of the FSM.
- Elaboration $error if frame_period < sck_half*(2*frame_bits+1)+2, if w_out < w_adc, or if w_adc > frame_bits.
- FSM states:
  - IDLE: cs=1, sck=1. If the frame counter is 0 and en=1: go to LEAD, cs<=0, busy<=1. If en=0, stay in IDLE; no valid pulses.
  - LEAD: hold sck=1 for sck_half cycles, then go to SHIFT.
  - SHIFT: per bit, sck=0 for sck_half cycles, then sck=1 for sck_half cycles. On the clk edge where sck goes 0->1, each channel shift register takes in sdo[k], left shift, MSB first. After the high phase of bit frame_bits-1, go to DONE with cs<=1, busy<=0.
  - DONE: one cycle. For each channel, take raw = low w_adc bits of its shift register.
    - If offset_binary=1, compute signed = raw - 2^(w_adc-1) modulo 2^w_adc; otherwise signed = raw.
    - value slice <= sign-extend(signed) to w_out.
    - clip[k] <= (raw == 0) or (raw == all ones).
    - valid <= 1 for exactly this cycle, then go to IDLE.
- Leading frame_bits-w_adc bits are captured and discarded.
- Latency: frame-start cycle (cs falls) to valid = sck_half*(2*frame_bits+1)+1 cycles; 133 at defaults.
- value and clip hold between valid pulses.
- en deassert mid-frame: the current frame completes and produces valid; no new frame starts.
- en assert mid-period: the first frame starts at the next frame counter wrap to 0.
- rst_n assert mid-frame: cs and sck return to 1 asynchronously in the same instant, and value is cleared. No valid is issued for the partial frame.
- sdo is sampled directly with no synchronizer; the ADC launches on the SCK falling edge, giving sck_half cycles of setup.

Test Plan:
- Defaults, n_ch=1, ADC model returns 0x800 -> cs low for exactly 132 cycles; valid pulse at +133; value=24'h000000, clip=0; next valid exactly 2083 cycles later.
- n_ch=2, ch0 code 0xFFF, ch1 code 0x000 -> value[23:0]=24'h0007FF, value[47:24]=24'hFFF800, clip=2'b11.
- offset_binary=0, code 0x800 -> value=24'hFFF800, clip=0; code 0x7FF -> value=24'h0007FF, clip=0.
- Leading-bit check: ADC model drives 1s on the 4 leading bits with code 0x123 -> value=0x123-0x800=24'hFFF923; leading 1s ignored.
- en dropped 10 cycles after cs falls -> that frame still gives valid; afterwards cs stays 1 and there are no further valid pulses. en re-asserted -> cs falls only when the frame counter is 0.
- rst_n pulsed low while sck=0 mid-frame -> cs=1, sck=1, value=0 immediately; no valid for that frame; normal frames resume after reset.

Source files
------------

// File: rtl/spi_adc_multichannel_receiver.sv
// rtl/spi_adc_multichannel_receiver.sv - shared CS/SCK SPI capture of N serial ADCs into signed samples
// One frame per sample period; all channels shift together and publish on a single valid strobe.
module spi_adc_multichannel_receiver #(
   parameter int clk_mhz        = 100,
   parameter int sample_rate_hz = 48000,
   parameter int sck_half       = 4,
   parameter int n_ch           = 1,
   parameter int frame_bits     = 16,
   parameter int w_adc          = 12,
   parameter int w_out          = 24,
   parameter bit offset_binary  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [n_ch-1:0]       sdo,
   output logic                  cs,
   output logic                  sck,
   output logic [n_ch*w_out-1:0] value,
   output logic [n_ch-1:0]       clip,
   output logic                  valid,
   output logic                  busy
);
   localparam int frame_period = clk_mhz * 1000000 / sample_rate_hz;
   localparam int fc_w = (frame_period > 1) ? $clog2(frame_period) : 1;
   localparam int hc_w = (sck_half > 1) ? $clog2(sck_half) : 1;
   localparam int bc_w = (frame_bits > 1) ? $clog2(frame_bits) : 1;
   localparam logic [fc_w-1:0]  fc_last = fc_w'(frame_period - 1);
   localparam logic [hc_w-1:0]  hc_last = hc_w'(sck_half - 1);
   localparam logic [bc_w-1:0]  bc_last = bc_w'(frame_bits - 1);
   localparam logic [w_adc-1:0] adc_msb = w_adc'(1) << (w_adc - 1);

   generate
      if (frame_period < sck_half * (2 * frame_bits + 1) + 2) begin : g_err_period
         $error("frame_period too short for one SPI frame");
      end
      if (w_out < w_adc) begin : g_err_wout
         $error("w_out must be >= w_adc");
      end
      if (w_adc > frame_bits) begin : g_err_wadc
         $error("w_adc must be <= frame_bits");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_t;

   state_t                state;
   logic [1:0]            rst_sync;
   logic                  rst_i_n;
   logic [fc_w-1:0]       frame_cnt;
   logic [hc_w-1:0]       half_cnt;
   logic [bc_w-1:0]       bit_cnt;
   logic [frame_bits-1:0] shreg [n_ch];
   logic [n_ch*w_out-1:0] conv;
   logic [n_ch-1:0]       clip_d;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n)                frame_cnt <= '0;
      else if (frame_cnt == fc_last) frame_cnt <= '0;
      else                         frame_cnt <= frame_cnt + fc_w'(1);
   end

   function automatic logic [w_out-1:0] to_signed(input logic [w_adc-1:0] raw);
      logic signed [w_adc-1:0] sv;
      sv = offset_binary ? signed'(raw ^ adc_msb) : signed'(raw);
      return w_out'(sv);
   endfunction

   always_comb begin
      conv   = '0;
      clip_d = '0;
      for (int k = 0; k < n_ch; k++) begin
         conv[k*w_out +: w_out] = to_signed(shreg[k][w_adc-1:0]);
         clip_d[k] = (shreg[k][w_adc-1:0] == '0) || (shreg[k][w_adc-1:0] == '1);
      end
   end

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         state    <= IDLE;
         cs       <= 1'b1;
         sck      <= 1'b1;
         busy     <= 1'b0;
         valid    <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         value    <= '0;
         clip     <= '0;
         for (int k = 0; k < n_ch; k++) shreg[k] <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               cs  <= 1'b1;
               sck <= 1'b1;
               if (frame_cnt == '0 && en) begin
                  state    <= LEAD;
                  cs       <= 1'b0;
                  busy     <= 1'b1;
                  half_cnt <= '0;
               end
            end
            LEAD: begin
               if (half_cnt == hc_last) begin
                  half_cnt <= '0;
                  bit_cnt  <= '0;
                  sck      <= 1'b0;
                  state    <= SHIFT;
               end else begin
                  half_cnt <= half_cnt + hc_w'(1);
               end
            end
            SHIFT: begin
               if (half_cnt != hc_last) begin
                  half_cnt <= half_cnt + hc_w'(1);
               end else begin
                  half_cnt <= '0;
                  // sdo is captured on the same edge that raises sck
                  if (!sck) begin
                     sck <= 1'b1;
                     for (int k = 0; k < n_ch; k++)
                        shreg[k] <= (shreg[k] << 1) | frame_bits'(sdo[k]);
                  end else if (bit_cnt == bc_last) begin
                     state <= DONE;
                     cs    <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     sck     <= 1'b0;
                     bit_cnt <= bit_cnt + bc_w'(1);
                  end
               end
            end
            DONE: begin
               value <= conv;
               clip  <= clip_d;
               valid <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_adc_multichannel_receiver.sv
// tb/tb_spi_adc_multichannel_receiver.sv - randomized self-checking bench for spi_adc_multichannel_receiver
// DUT a: defaults with two channels; DUT b: one two's-complement channel at a faster frame rate.
module tb_spi_adc_multichannel_receiver;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_a = 1'b0, en_b = 1'b0;
   logic [1:0]  sdo_a = '0;
   logic        sdo_b = 1'b0;
   logic        cs_a, sck_a, valid_a, busy_a, cs_b, sck_b, valid_b, busy_b;
   logic [47:0] value_a;
   logic [23:0] value_b;
   logic [1:0]  clip_a;
   logic        clip_b;
   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_adc_multichannel_receiver #(.n_ch(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .sdo(sdo_a), .cs(cs_a), .sck(sck_a),
      .value(value_a), .clip(clip_a), .valid(valid_a), .busy(busy_a));

   spi_adc_multichannel_receiver #(.sample_rate_hz(400000), .n_ch(1), .offset_binary(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .sdo(sdo_b), .cs(cs_b), .sck(sck_b),
      .value(value_b), .clip(clip_b), .valid(valid_b), .busy(busy_b));

   // ADC models: MSB out when cs falls, following bits after each sck fall.
   logic [15:0] next_a [2];
   logic [15:0] cur_a [2];
   logic [15:0] next_b = '0, cur_b = '0;
   int          idx_a = 0, idx_b = 0;
   logic        cs_pa = 1'b1, sck_pa = 1'b1, cs_pb = 1'b1, sck_pb = 1'b1;

   always @(negedge clk) begin
      if (cs_pa && !cs_a) begin
         cur_a = next_a;
         idx_a = 0;
         for (int k = 0; k < 2; k++) sdo_a[k] = cur_a[k][15];
      end else if (!cs_a) begin
         if (!sck_pa && sck_a) idx_a++;
         else if (sck_pa && !sck_a && idx_a > 0 && idx_a < 16)
            for (int k = 0; k < 2; k++) sdo_a[k] = cur_a[k][15 - idx_a];
      end
      cs_pa = cs_a;
      sck_pa = sck_a;
   end

   always @(negedge clk) begin
      if (cs_pb && !cs_b) begin
         cur_b = next_b;
         idx_b = 0;
         sdo_b = cur_b[15];
      end else if (!cs_b) begin
         if (!sck_pb && sck_b) idx_b++;
         else if (sck_pb && !sck_b && idx_b > 0 && idx_b < 16) sdo_b = cur_b[15 - idx_b];
      end
      cs_pb = cs_b;
      sck_pb = sck_b;
   end

   function automatic logic [23:0] exp_val(input int code, input bit ob);
      int e;
      if (ob) e = code - 2048;
      else    e = (code >= 2048) ? code - 4096 : code;
      return 24'(e);
   endfunction

   function automatic bit exp_clip(input int code);
      return (code == 0) || (code == 4095);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_cs_fall(input bit sel, input int bound, output int t);
      int n;
      n = 0;
      t = -1;
      while (n < bound && t < 0) begin
         @(negedge clk);
         n++;
         if ((sel ? cs_b : cs_a) == 1'b0) t = cyc;
      end
      chk(sel ? "cs_b_fall_seen" : "cs_a_fall_seen", t >= 0, 1'b1);
   endtask

   task automatic wait_valid(input bit sel, input int bound, output int t);
      int n;
      n = 0;
      t = -1;
      while (n < bound && t < 0) begin
         @(negedge clk);
         n++;
         if ((sel ? valid_b : valid_a) == 1'b1) t = cyc;
      end
      chk(sel ? "valid_b_seen" : "valid_a_seen", t >= 0, 1'b1);
   endtask

   task automatic frame_a(input string tag, input logic [3:0] l0, input logic [11:0] c0,
                          input logic [3:0] l1, input logic [11:0] c1, output int tf, output int tv);
      next_a[0] = {l0, c0};
      next_a[1] = {l1, c1};
      wait_cs_fall(1'b0, 2200, tf);
      wait_valid(1'b0, 200, tv);
      chk({tag, "_latency"}, tv - tf, 133);
      chk({tag, "_ch0"}, value_a[23:0], exp_val(c0, 1'b1));
      chk({tag, "_ch1"}, value_a[47:24], exp_val(c1, 1'b1));
      chk({tag, "_clip"}, clip_a, {exp_clip(c1), exp_clip(c0)});
   endtask

   task automatic frame_b(input string tag, input logic [11:0] c, output int tf, output int tv);
      next_b = {4'($urandom), c};
      wait_cs_fall(1'b1, 300, tf);
      wait_valid(1'b1, 200, tv);
      chk({tag, "_latency"}, tv - tf, 133);
      chk({tag, "_value"}, value_b, exp_val(c, 1'b0));
      chk({tag, "_clip"}, clip_b, exp_clip(c));
   endtask

   initial begin
      int          tf, tv, tv_prev, t_ref, n, nlow, npulse, bad, rises;
      logic        sp;
      logic [11:0] ca, cb;
      next_a[0] = '0;
      next_a[1] = '0;

      repeat (3) @(negedge clk);
      chk("rst_cs", cs_a, 1'b1);
      chk("rst_sck", sck_a, 1'b1);
      chk("rst_value", value_a, 48'h0);
      chk("rst_clip", clip_a, 2'b00);
      chk("rst_valid", valid_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);

      // first frame: cs width, sck count, latency, mid-scale code
      rst_n = 1'b1;
      en_a  = 1'b1;
      ca = 12'($urandom);
      next_a[0] = {4'h0, 12'h800};
      next_a[1] = {4'($urandom), ca};
      wait_cs_fall(1'b0, 50, tf);
      nlow = 1;
      bad = 0;
      rises = 0;
      sp = sck_a;
      while (cs_a == 1'b0 && nlow < 300) begin
         @(negedge clk);
         if (cs_a == 1'b0) nlow++;
         if (busy_a !== ~cs_a) bad++;
         if (!sp && sck_a) rises++;
         sp = sck_a;
      end
      chk("f1_cs_low_cycles", nlow, 132);
      chk("f1_busy_tracks_cs", bad, 0);
      chk("f1_sck_rises", rises, 16);
      wait_valid(1'b0, 5, tv);
      chk("f1_latency", tv - tf, 133);
      chk("f1_ch0", value_a[23:0], 24'h000000);
      chk("f1_ch1", value_a[47:24], exp_val(ca, 1'b1));
      chk("f1_clip", clip_a, {exp_clip(ca), 1'b0});
      @(negedge clk);
      chk("f1_valid_one_cycle", valid_a, 1'b0);
      t_ref = tf;
      tv_prev = tv;

      frame_a("f2", 4'h0, 12'hFFF, 4'h0, 12'h000, tf, tv);
      chk("f2_period", tv - tv_prev, 2083);
      chk("f2_ch0_lit", value_a[23:0], 24'h0007FF);
      chk("f2_ch1_lit", value_a[47:24], 24'hFFF800);
      chk("f2_clip_lit", clip_a, 2'b11);
      repeat (50) @(negedge clk);
      chk("f2_hold", value_a, 48'hFFF800_0007FF);

      frame_a("f3_lead", 4'hF, 12'h123, 4'($urandom), 12'($urandom), tf, tv);
      chk("f3_ch0_lit", value_a[23:0], 24'hFFF923);

      for (int i = 0; i < 4; i++)
         frame_a("rnd", 4'($urandom), 12'($urandom), 4'($urandom), 12'($urandom), tf, tv);

      // en dropped mid-frame: that frame completes, then silence
      ca = 12'($urandom);
      cb = 12'($urandom);
      next_a[0] = {4'($urandom), ca};
      next_a[1] = {4'($urandom), cb};
      wait_cs_fall(1'b0, 2200, tf);
      repeat (10) @(negedge clk);
      en_a = 1'b0;
      wait_valid(1'b0, 200, tv);
      chk("endrop_latency", tv - tf, 133);
      chk("endrop_ch0", value_a[23:0], exp_val(ca, 1'b1));
      chk("endrop_ch1", value_a[47:24], exp_val(cb, 1'b1));
      npulse = 0;
      nlow = 0;
      repeat (2 * 2083 + 100) begin
         @(negedge clk);
         if (valid_a) npulse++;
         if (!cs_a) nlow++;
      end
      chk("endrop_no_valid", npulse, 0);
      chk("endrop_cs_idle", nlow, 0);
      repeat ($urandom_range(1, 2000)) @(negedge clk);
      en_a = 1'b1;
      frame_a("reen", 4'($urandom), 12'($urandom), 4'($urandom), 12'($urandom), tf, tv);
      chk("reen_on_wrap", (tf - t_ref) % 2083, 0);

      // reset asserted while sck is low inside a frame
      next_a[0] = {4'($urandom), 12'($urandom)};
      next_a[1] = {4'($urandom), 12'($urandom)};
      wait_cs_fall(1'b0, 2200, tf);
      repeat (20) @(negedge clk);
      n = 0;
      while (sck_a !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rstmid_sck_low_before", sck_a, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_cs", cs_a, 1'b1);
      chk("rstmid_sck", sck_a, 1'b1);
      chk("rstmid_value", value_a, 48'h0);
      chk("rstmid_busy", busy_a, 1'b0);
      npulse = 0;
      repeat (5) begin
         @(negedge clk);
         if (valid_a) npulse++;
      end
      chk("rstmid_no_valid", npulse, 0);
      rst_n = 1'b1;
      frame_a("post_rst", 4'($urandom), 12'($urandom), 4'($urandom), 12'($urandom), tf, tv);

      // two's-complement channel on the faster instance
      en_b = 1'b1;
      frame_b("b_800", 12'h800, tf, tv);
      chk("b_800_lit", value_b, 24'hFFF800);
      tv_prev = tv;
      frame_b("b_7ff", 12'h7FF, tf, tv);
      chk("b_7ff_lit", value_b, 24'h0007FF);
      chk("b_period", tv - tv_prev, 250);
      frame_b("b_000", 12'h000, tf, tv);
      for (int i = 0; i < 3; i++) frame_b("b_rnd", 12'($urandom), tf, tv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
